// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a 4-entry first-word-fall-through FIFO.
// Latency: byte visible (clk_per_bit-1)/2 + 9*clk_per_bit cycles (10 with parity) after the synchronized start edge.
// Backpressure: none on the serial line; a good frame arriving with the FIFO full and no pop is dropped and sets overflow.
module uart_rx_fifo #(
   parameter logic [7:0] clk_per_bit = 8'd50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_serial,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       rx_done,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overflow
);

   // START waits half a bit (rounded down) so every later sample lands mid-bit.
   localparam logic [7:0] start_last = ((clk_per_bit - 8'd1) >> 1) - 8'd1;
   localparam logic [7:0] bit_last   = clk_per_bit - 8'd1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   logic       rx_meta;
   logic       rx_sync;
   logic       rx_sync_d;
   state_t     state;
   logic [7:0] cnt;
   logic [2:0] bit_idx;
   logic [7:0] shreg;

   logic [7:0] mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] count;
   logic       fifo_full;
   logic       stop_tick;
   logic       good_stop;
   logic       push;
   logic       pop;

`ifdef UART_RX_PARITY_EN
   logic       par_bad;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta   <= 1'b1;
         rx_sync   <= 1'b1;
         rx_sync_d <= 1'b1;
      end else begin
         rx_meta   <= rx_serial;
         rx_sync   <= rx_meta;
         rx_sync_d <= rx_sync;
      end
   end

   assign stop_tick = (state == STOP) && (cnt == bit_last);
`ifdef UART_RX_PARITY_EN
   assign good_stop = stop_tick && rx_sync && !par_bad;
`else
   assign good_stop = stop_tick && rx_sync;
`endif

   assign rd_valid  = (count != 3'd0);
   assign rd_data   = rd_valid ? mem[rd_ptr] : 8'h00;
   assign fifo_full = count[2];
   assign pop       = rd_en && rd_valid;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push      = good_stop && (!fifo_full || pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         bit_idx    <= 3'd0;
         shreg      <= 8'h00;
         rx_done    <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         rx_done   <= push;
         frame_err <= stop_tick && !rx_sync;
`ifdef UART_RX_PARITY_EN
         parity_err <= stop_tick && rx_sync && par_bad;
`endif
         if (good_stop && !push) begin
            overflow <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (rx_sync_d && !rx_sync) begin
                  state   <= START;
                  cnt     <= 8'd0;
                  bit_idx <= 3'd0;
               end
            end
            START: begin
               if (cnt == start_last) begin
                  cnt   <= 8'd0;
                  state <= rx_sync ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DATA: begin
               if (cnt == bit_last) begin
                  cnt     <= 8'd0;
                  shreg   <= {rx_sync, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt == bit_last) begin
                  cnt     <= 8'd0;
                  par_bad <= (rx_sync != ^shreg);
                  state   <= STOP;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
`endif
            STOP: begin
               if (cnt == bit_last) begin
                  cnt   <= 8'd0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 8'd0;
            end
         endcase
      end
   end

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wr_ptr] <= shreg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random frames, scored against a queue-based frame model.
module tb_uart_rx_fifo;

   localparam int cpb = 50;
`ifdef UART_RX_PARITY_EN
   localparam bit par_on = 1'b1;
`else
   localparam bit par_on = 1'b0;
`endif
   localparam int lat = (cpb - 1) / 2 + (par_on ? 10 : 9) * cpb;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_serial;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rx_done;
   logic       frame_err;
   logic       parity_err;
   logic       overflow;

   uart_rx_fifo #(.clk_per_bit(8'd50)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_serial  (rx_serial),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rx_done    (rx_done),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_pass = 0;
   int         cyc = 0;
   logic [7:0] exp_q [$];
   int         exp_done = 0;
   int         exp_ferr = 0;
   int         exp_perr = 0;
   bit         exp_ovf = 1'b0;
   int         cnt_done = 0;
   int         cnt_ferr = 0;
   int         cnt_perr = 0;
   int         last_done_cyc = 0;
   bit         rd_auto = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitor: counts pulses and, when reading is enabled, pops and scores the FIFO head.
   initial begin
      rd_en = 1'b0;
      forever begin
         @(negedge clk);
         rd_en = 1'b0;
         if (rx_done) begin
            cnt_done++;
            last_done_cyc = cyc;
         end
         if (frame_err) cnt_ferr++;
         if (parity_err) cnt_perr++;
         if (rd_valid && rd_auto && !rst) begin
            check("fifo_byte_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("rd_data", rd_data, exp_q.pop_front());
            rd_en = 1'b1;
         end
      end
   end

   // Frame model: decides the outcome of a complete frame at the moment it is sent.
   task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par,
                             input int cut, input int gap, output int t_start);
      logic [10:0] bits;
      int          nb;
      int          n;
      bits      = 11'h7FF;
      bits[0]   = 1'b0;
      bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
      bits[9]   = (^b) ^ bad_par;
      bits[10]  = ~bad_stop;
      nb        = 11;
`else
      bits[9]   = ~bad_stop;
      nb        = 10;
`endif
      if (cut == 0) begin
         if (bad_stop) exp_ferr++;
         else if (par_on && bad_par) exp_perr++;
         else if (rd_auto || exp_q.size() < 4) begin
            exp_q.push_back(b);
            exp_done++;
         end else exp_ovf = 1'b1;
      end
      n = 0;
      t_start = 0;
      for (int i = 0; i < nb; i++) begin
         for (int j = 0; j < cpb; j++) begin
            @(negedge clk);
            rx_serial = bits[i];
            if (n == 0) t_start = cyc;
            n++;
            if (cut != 0 && n >= cut) return;
         end
      end
      @(negedge clk);
      rx_serial = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_drain(input string name);
      int budget;
      budget = 200;
      while (exp_q.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check(name, exp_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_valid"}, rd_valid, 0);
      check({tag, "_rd_data"}, rd_data, 8'h00);
      check({tag, "_rx_done"}, rx_done, 0);
      check({tag, "_frame_err"}, frame_err, 0);
      check({tag, "_parity_err"}, parity_err, 0);
      check({tag, "_overflow"}, overflow, 0);
   endtask

   initial begin
      logic [7:0] b;
      int         t0;
      bit         bs;
      bit         bp;
      rst       = 1'b1;
      rx_serial = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Single byte, held in the FIFO until read.
      rd_auto = 1'b0;
      send_frame(8'hA9, 1'b0, 1'b0, 0, 20, t0);
      check("a9_rd_valid", rd_valid, 1);
      check("a9_rd_data", rd_data, 8'hA9);
      check("a9_done_count", cnt_done, exp_done);
      check("a9_latency_in_window",
            ((last_done_cyc - t0) >= lat + 2) && ((last_done_cyc - t0) <= lat + 4), 1);
      rd_auto = 1'b1;
      wait_drain("a9_drain");
      check("a9_rd_valid_after_pop", rd_valid, 0);

      // Five bytes with no reads: fifth overflows.
      rd_auto = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         b = 8'(k);
         send_frame(b, 1'b0, 1'b0, 0, 30, t0);
      end
      check("ovf_flag", overflow, exp_ovf);
      check("ovf_done_count", cnt_done, exp_done);
      check("ovf_rd_valid_full", rd_valid, 1);
      rd_auto = 1'b1;
      wait_drain("ovf_drain");
      check("ovf_rd_valid_after", rd_valid, 0);
      check("ovf_flag_sticky", overflow, exp_ovf);

      // Low stop bit, then a good frame.
      send_frame(8'h55, 1'b1, 1'b0, 0, cpb, t0);
      check("ferr_count", cnt_ferr, exp_ferr);
      check("ferr_rd_valid", rd_valid, 0);
      send_frame(8'h3C, 1'b0, 1'b0, 0, 20, t0);
      wait_drain("ferr_next_drain");
      check("ferr_next_done_count", cnt_done, exp_done);

      // Short low glitch must be rejected silently.
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         rx_serial = 1'b0;
      end
      @(negedge clk);
      rx_serial = 1'b1;
      repeat (700) @(negedge clk);
      check("glitch_done_count", cnt_done, exp_done);
      check("glitch_ferr_count", cnt_ferr, exp_ferr);
      check("glitch_rd_valid", rd_valid, 0);

      // Reset 200 cycles into a frame.
      send_frame(8'hA9, 1'b0, 1'b0, 200, 0, t0);
      rst       = 1'b1;
      rx_serial = 1'b1;
      @(negedge clk);
      check_reset_outputs("midrst");
      exp_q.delete();
      exp_ovf = 1'b0;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      send_frame(8'h5A, 1'b0, 1'b0, 0, 20, t0);
      wait_drain("midrst_drain");
      check("midrst_done_count", cnt_done, exp_done);
      check("midrst_ferr_count", cnt_ferr, exp_ferr);

`ifdef UART_RX_PARITY_EN
      send_frame(8'hA9, 1'b0, 1'b1, 0, 20, t0);
      check("par_err_count", cnt_perr, exp_perr);
      check("par_rd_valid", rd_valid, 0);
      send_frame(8'hA9, 1'b0, 1'b0, 0, 20, t0);
      wait_drain("par_good_drain");
      check("par_good_done_count", cnt_done, exp_done);
`endif

      // Random frames; reading randomly paused so the FIFO sometimes fills.
      for (int k = 0; k < 16; k++) begin
         rd_auto = ($urandom_range(0, 2) != 0);
         b  = 8'($urandom);
         bs = ($urandom_range(0, 4) == 0);
         bp = ($urandom_range(0, 4) == 0);
         send_frame(b, bs, bp, 0, $urandom_range(cpb, 3 * cpb), t0);
      end
      rd_auto = 1'b1;
      wait_drain("rand_drain");
      check("rand_done_count", cnt_done, exp_done);
      check("rand_ferr_count", cnt_ferr, exp_ferr);
      check("rand_perr_count", cnt_perr, exp_perr);
      check("rand_overflow", overflow, exp_ovf);
      check("rand_rd_valid", rd_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      repeat (80000) @(posedge clk);
      $display("FAIL watchdog: cycle budget expired, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The module SHALL have one parameter: clk_per_bit, default 8'd50, the number of clk cycles per serial bit (legal range 4..255).
REQ-002 clk  input  1  single clock for all logic; all registers SHALL update on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 rx_serial  input  1  asynchronous UART line; idles high.
REQ-005 rd_en  input  1  pop request for the FIFO head.
REQ-006 rd_data  output  8  FIFO head byte, first-word fall-through.
REQ-007 rd_valid  output  1  FIFO not empty.
REQ-008 rx_done  output  1  one-cycle pulse when a good frame is written to the FIFO.
REQ-009 frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-010 parity_err  output  1  one-cycle pulse on a parity mismatch; tied 0 when parity is compiled out.
REQ-011 overflow  output  1  sticky flag: a good frame arrived while the FIFO was full.

Function
REQ-012 rx_serial SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized line.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY SHALL be reachable only when parity is compiled in.
REQ-014 IDLE: a synchronized high-to-low transition SHALL move the FSM to START and clear the bit counter.
REQ-015 START: after (clk_per_bit-1)/2 further cycles, the line SHALL be sampled; low -> DATA, high -> IDLE (glitch rejected; no error pulse).
REQ-016 DATA: the line SHALL be sampled every clk_per_bit cycles, 8 bits, LSB first, into a shift register; after bit 7 the FSM SHALL go to PARITY (if compiled in) or STOP.
REQ-017 STOP: the line SHALL be sampled clk_per_bit cycles after the previous sample.
REQ-018 STOP, high sample, no parity error: the byte SHALL be pushed, rx_done SHALL pulse for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-019 STOP, low sample: frame_err SHALL pulse, the byte SHALL be discarded, and the FSM SHALL return to IDLE; a new start SHALL require a fresh high-to-low edge.
REQ-020 The FIFO SHALL be 4 entries deep with 2-bit read/write pointers that wrap modulo 4 and a 3-bit occupancy count.
REQ-021 rd_en with rd_valid=1 SHALL pop the head on that edge; rd_en with rd_valid=0 SHALL be ignored.
REQ-022 A push while the FIFO is full and no pop occurs in that cycle SHALL drop the byte, set overflow, and suppress rx_done.
REQ-023 A simultaneous push and pop SHALL both take effect, leaving the count unchanged, including when the FIFO is full.
REQ-024 The serial-to-FIFO byte latency SHALL be (clk_per_bit-1)/2 + 9*clk_per_bit cycles (10 with parity) after the synchronized start edge, +-1 cycle.

Reset
REQ-025 rst=1 at a clock edge SHALL force: FSM to IDLE, counters and pointers to 0, synchronizer flops to 1, rd_valid=0, rd_data=8'h00, rx_done=0, frame_err=0, parity_err=0, overflow=0.
REQ-026 rst asserted mid-frame SHALL abandon the frame; no pulse output SHALL assert in the cycle after the reset edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: one even-parity bit SHALL be expected between data bit 7 and the stop bit; on a mismatch the frame SHALL be discarded, parity_err SHALL pulse at the stop sample, and frame_err SHALL take precedence if the stop bit is also low.
REQ-028 Macro UART_RX_PARITY_EN undefined: the frame SHALL be 8N1, the PARITY state SHALL be absent, and parity_err SHALL be constant 0.

Verification
REQ-029 clk_per_bit=50, 10 ns clock, send 8'hA9 8N1 -> one rx_done pulse; rd_valid=1; rd_data=8'hA9; rd_en pulse -> rd_valid=0.
REQ-030 Send 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 with no reads -> first four bytes read back in order; overflow=1; only four rx_done pulses.
REQ-031 Send 8'h55 with the stop bit driven low -> frame_err pulses once; rd_valid stays 0; a following good 8'h3C is received correctly.
REQ-032 Line pulsed low for 10 cycles, then high -> FSM returns to IDLE; no rx_done; no frame_err.
REQ-033 rst asserted 200 cycles into an 8'hA9 frame -> all outputs at reset values; a subsequent 8'h5A frame is received correctly.
REQ-034 UART_RX_PARITY_EN defined, send 8'hA9 with parity bit 1 (wrong) -> parity_err pulses; FIFO stays empty; with parity bit 0 -> rd_data=8'hA9.
